// File: rtl/pmu_smp_acq.sv
// PMU sample acquisition: averages 2^AVG_LOG2 ADC conversions per start request and stores the
// result in a simple dual-port sample buffer read out by the packer.
module pmu_smp_acq #(
  parameter int unsigned ADC_DW   = 16,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned BUF_AW   = 10,
  parameter int unsigned TMO_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmu_smp_start,
  input  logic              pmu_rd_start,
  output logic              adc_ready,
  output logic              pmu_smp_done,
  output logic              adc_conv,
  input  logic              adc_data_vld,
  input  logic [ADC_DW-1:0] adc_data,
  input  logic              buf_rd_en,
  input  logic [BUF_AW-1:0] buf_rd_addr,
  output logic [ADC_DW-1:0] buf_rd_data,
  output logic [BUF_AW:0]   smp_num,
  output logic              smp_ovf,
  output logic              smp_tmo
);

  localparam int unsigned AccW = ADC_DW + AVG_LOG2;
  localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StConv, StWait, StWr, StDone} state_e;

  state_e                state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [AVG_LOG2-1:0]   conv_cnt_q, conv_cnt_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [BUF_AW:0]       smp_num_q, smp_num_d;
  logic                  smp_ovf_q, smp_ovf_d;
  logic                  smp_tmo_q, smp_tmo_d;
  logic [ADC_DW-1:0]     buf_rd_data_q;
  logic [ADC_DW-1:0]     mem_q [2**BUF_AW];

  logic                   wr_en;
  logic signed [AccW-1:0] adc_ext;
  logic signed [AccW-1:0] avg;

  assign adc_ext = {{AVG_LOG2{adc_data[ADC_DW-1]}}, adc_data};
  // Arithmetic shift floors the mean toward -inf.
  assign avg     = acc_q >>> AVG_LOG2;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    conv_cnt_d = conv_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    smp_num_d  = smp_num_q;
    smp_ovf_d  = smp_ovf_q;
    smp_tmo_d  = smp_tmo_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pmu_smp_start) begin
          acc_d      = '0;
          conv_cnt_d = '0;
          state_d    = StConv;
        end
      end
      StConv: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (adc_data_vld) begin
          acc_d = acc_q + adc_ext;
          if (conv_cnt_q == {AVG_LOG2{1'b1}}) begin
            state_d = StWr;
          end else begin
            conv_cnt_d = conv_cnt_q + AVG_LOG2'(1);
            state_d    = StConv;
          end
        end else if (tmo_cnt_q == TmoW'(TMO_CYC - 1)) begin
          smp_tmo_d = 1'b1;
          state_d   = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StWr: begin
        state_d = StDone;
        if (!smp_num_q[BUF_AW]) begin
          wr_en     = 1'b1;
          smp_num_d = smp_num_q + (BUF_AW + 1)'(1);
        end else begin
          smp_ovf_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new read-out cycle wins over any write or flag update in flight.
    if (pmu_rd_start) begin
      smp_num_d = '0;
      smp_ovf_d = 1'b0;
      smp_tmo_d = 1'b0;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      conv_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      smp_num_q     <= '0;
      smp_ovf_q     <= 1'b0;
      smp_tmo_q     <= 1'b0;
      buf_rd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      conv_cnt_q <= conv_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      smp_num_q  <= smp_num_d;
      smp_ovf_q  <= smp_ovf_d;
      smp_tmo_q  <= smp_tmo_d;
      if (buf_rd_en) begin
        buf_rd_data_q <= mem_q[buf_rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[smp_num_q[BUF_AW-1:0]] <= avg[ADC_DW-1:0];
    end
  end

  assign adc_ready    = (state_q == StIdle);
  assign adc_conv     = (state_q == StConv);
  assign pmu_smp_done = (state_q == StDone);
  assign buf_rd_data  = buf_rd_data_q;
  assign smp_num      = smp_num_q;
  assign smp_ovf      = smp_ovf_q;
  assign smp_tmo      = smp_tmo_q;

endmodule

// File: tb/tb_pmu_smp_acq.sv
// Randomized bench for pmu_smp_acq against a behavioural model of averaging, buffering and flags.
module tb_pmu_smp_acq;

  localparam int ADC_DW  = 16;
  localparam int BUF_AW  = 10;
  localparam int DEPTH   = 1 << BUF_AW;
  localparam int TMO_CYC = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pmu_smp_start = 1'b0;
  logic              pmu_rd_start = 1'b0;
  logic              adc_ready, pmu_smp_done, adc_conv;
  logic              adc_data_vld = 1'b0;
  logic [ADC_DW-1:0] adc_data = '0;
  logic              buf_rd_en = 1'b0;
  logic [BUF_AW-1:0] buf_rd_addr = '0;
  logic [ADC_DW-1:0] buf_rd_data;
  logic [BUF_AW:0]   smp_num;
  logic              smp_ovf, smp_tmo;

  pmu_smp_acq dut (
    .clk          (clk),
    .rst          (rst),
    .pmu_smp_start(pmu_smp_start),
    .pmu_rd_start (pmu_rd_start),
    .adc_ready    (adc_ready),
    .pmu_smp_done (pmu_smp_done),
    .adc_conv     (adc_conv),
    .adc_data_vld (adc_data_vld),
    .adc_data     (adc_data),
    .buf_rd_en    (buf_rd_en),
    .buf_rd_addr  (buf_rd_addr),
    .buf_rd_data  (buf_rd_data),
    .smp_num      (smp_num),
    .smp_ovf      (smp_ovf),
    .smp_tmo      (smp_tmo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(posedge clk) if (pmu_smp_done === 1'b1) done_cnt++;

  // Reference model
  logic [ADC_DW-1:0]        mbuf [DEPTH];
  int                       mnum = 0;
  bit                       movf = 0;
  bit                       mtmo = 0;
  logic signed [ADC_DW-1:0] vals [8];

  function automatic int floor_avg8(input int sum);
    int a;
    a = sum / 8;
    if (sum < 0 && (sum % 8) != 0) a = a - 1;
    return a;
  endfunction

  task automatic rand_vals();
    for (int i = 0; i < 8; i++) vals[i] = ADC_DW'($urandom);
  endtask

  task automatic check_status(input string name);
    checks++;
    if (smp_num !== (BUF_AW + 1)'(mnum) || smp_ovf !== movf || smp_tmo !== mtmo) begin
      errors++;
      $display("FAIL %s: num/ovf/tmo got %0d/%0b/%0b expected %0d/%0b/%0b", name, smp_num,
               smp_ovf, smp_tmo, mnum, movf, mtmo);
    end
  endtask

  // lat < 0 picks a random ADC latency per conversion; stall_k >= 0 withholds that result.
  task automatic run_sample(input int lat, input int stall_k, input bit restart,
                            input bit rd_at_wr, output int done_cyc);
    int cyc, w, sum, l, avg;
    bit stalled, aborted;
    done_cyc = -1;
    stalled  = 0;
    aborted  = 0;
    sum      = 0;
    @(negedge clk);
    checks++;
    if (adc_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_start: got %b expected 1", adc_ready);
    end
    pmu_smp_start = 1'b1;
    @(negedge clk);
    pmu_smp_start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (adc_conv !== 1'b1 && w < 10) begin
        @(negedge clk);
        cyc++;
        w++;
      end
      checks++;
      if (adc_conv !== 1'b1) begin
        errors++;
        $display("FAIL conv_wait: adc_conv got %b expected 1 (conversion %0d)", adc_conv, k);
        aborted = 1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (k == stall_k) begin
        repeat (TMO_CYC - 1) @(negedge clk);
        checks++;
        if (pmu_smp_done !== 1'b0) begin
          errors++;
          $display("FAIL tmo_early: done got %b expected 0", pmu_smp_done);
        end
        @(negedge clk);
        checks++;
        if (pmu_smp_done !== 1'b1 || smp_tmo !== 1'b1) begin
          errors++;
          $display("FAIL tmo_done: done/tmo got %b/%b expected 1/1", pmu_smp_done, smp_tmo);
        end
        stalled = 1;
        break;
      end
      l = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
      repeat (l) begin
        @(negedge clk);
        cyc++;
      end
      adc_data_vld = 1'b1;
      adc_data     = vals[k];
      if (restart) pmu_smp_start = 1'b1;
      sum += int'(vals[k]);
      @(negedge clk);
      cyc++;
      adc_data_vld  = 1'b0;
      pmu_smp_start = 1'b0;
    end
    if (!stalled && !aborted) begin
      if (rd_at_wr) pmu_rd_start = 1'b1;
      checks++;
      if (pmu_smp_done !== 1'b0) begin
        errors++;
        $display("FAIL done_at_wr: got %b expected 0", pmu_smp_done);
      end
      @(negedge clk);
      cyc++;
      pmu_rd_start = 1'b0;
      checks++;
      if (pmu_smp_done !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse: got %b expected 1", pmu_smp_done);
      end
      done_cyc = cyc;
    end
    @(negedge clk);
    checks++;
    if (pmu_smp_done !== 1'b0 || adc_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_done: done/ready got %b/%b expected 0/1", pmu_smp_done, adc_ready);
    end
    if (stalled) begin
      mtmo = 1;
    end else if (!aborted) begin
      if (rd_at_wr) begin
        mnum = 0;
        movf = 0;
        mtmo = 0;
      end else if (mnum < DEPTH) begin
        avg = floor_avg8(sum);
        mbuf[mnum] = ADC_DW'(avg);
        mnum++;
      end else begin
        movf = 1;
      end
    end
    check_status("status_after_sample");
  endtask

  task automatic read_check(input int addr, input string name);
    @(negedge clk);
    buf_rd_en   = 1'b1;
    buf_rd_addr = BUF_AW'(addr);
    @(negedge clk);
    buf_rd_en   = 1'b0;
    buf_rd_addr = BUF_AW'($urandom);
    checks++;
    if (buf_rd_data !== mbuf[addr]) begin
      errors++;
      $display("FAIL %s: buf[%0d] got %h expected %h", name, addr, buf_rd_data, mbuf[addr]);
    end
    @(negedge clk);
    checks++;
    if (buf_rd_data !== mbuf[addr]) begin
      errors++;
      $display("FAIL %s_hold: got %h expected %h", name, buf_rd_data, mbuf[addr]);
    end
  endtask

  task automatic pulse_rd_start();
    @(negedge clk);
    pmu_rd_start = 1'b1;
    @(negedge clk);
    pmu_rd_start = 1'b0;
    mnum = 0;
    movf = 0;
    mtmo = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (smp_num !== '0 || smp_ovf !== 1'b0 || smp_tmo !== 1'b0 || pmu_smp_done !== 1'b0 ||
        adc_conv !== 1'b0 || buf_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: num=%0d ovf=%b tmo=%b done=%b conv=%b rd=%h expected all 0",
               smp_num, smp_ovf, smp_tmo, pmu_smp_done, adc_conv, buf_rd_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (adc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", adc_ready);
    end
  endtask

  task automatic test_basic();
    int dc;
    vals = '{16'sd100, 16'sd102, 16'sd98, 16'sd100, 16'sd101, 16'sd99, 16'sd100, 16'sd100};
    run_sample(0, -1, 0, 0, dc);
    checks++;
    if (dc != 18) begin
      errors++;
      $display("FAIL done_latency: got cycle %0d expected 18", dc);
    end
    read_check(0, "basic_avg");
  endtask

  task automatic test_negative();
    int dc;
    for (int i = 0; i < 8; i++) vals[i] = -16'sd3;
    run_sample(0, -1, 0, 0, dc);
    read_check(1, "neg_avg");
    for (int i = 0; i < 8; i++) vals[i] = 16'sd0;
    vals[5] = -16'sd1;
    run_sample(0, -1, 0, 0, dc);
    read_check(2, "floor_avg");
    for (int n = 0; n < 4; n++) begin
      rand_vals();
      run_sample(-1, -1, 0, 0, dc);
      read_check(mnum - 1, "rand_avg");
    end
  endtask

  task automatic test_timeout();
    int dc;
    rand_vals();
    run_sample(0, 2, 0, 0, dc);
  endtask

  task automatic test_rd_clear();
    int dc;
    pulse_rd_start();
    check_status("rd_clear");
    for (int i = 0; i < 8; i++) vals[i] = 16'sd555;
    run_sample(0, -1, 0, 1, dc);
    read_check(0, "clear_drops_write");
  endtask

  task automatic test_overflow();
    int dc;
    for (int n = 0; n < DEPTH + 1; n++) begin
      rand_vals();
      run_sample(-1, -1, 0, 0, dc);
    end
    check_status("overflow_flags");
    read_check(DEPTH - 1, "last_entry");
    read_check(0, "first_entry");
    pulse_rd_start();
    check_status("ovf_clear");
  endtask

  task automatic test_ignore();
    int dc, snap;
    bit bad;
    snap = done_cnt;
    rand_vals();
    run_sample(-1, -1, 1, 0, dc);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      adc_data_vld = 1'b1;
      adc_data     = ADC_DW'($urandom);
      if (adc_conv !== 1'b0 || adc_ready !== 1'b1) bad = 1;
    end
    @(negedge clk);
    adc_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    if (adc_conv !== 1'b0 || adc_ready !== 1'b1) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_vld_ignored: conv/ready got %b/%b expected 0/1", adc_conv, adc_ready);
    end
    checks++;
    if (done_cnt != snap + 1) begin
      errors++;
      $display("FAIL one_done_per_start: got %0d dones expected %0d", done_cnt - snap, 1);
    end
    check_status("ignore_status");
    read_check(mnum - 1, "restart_avg");
  endtask

  task automatic test_rst_mid();
    int dc, snap, w;
    snap = done_cnt;
    @(negedge clk);
    pmu_smp_start = 1'b1;
    @(negedge clk);
    pmu_smp_start = 1'b0;
    w = 0;
    while (adc_conv !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (adc_ready !== 1'b1 || pmu_smp_done !== 1'b0 || smp_num !== '0) begin
      errors++;
      $display("FAIL rst_mid: ready/done/num got %b/%b/%0d expected 1/0/0", adc_ready,
               pmu_smp_done, smp_num);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mnum = 0;
    movf = 0;
    mtmo = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != snap) begin
      errors++;
      $display("FAIL rst_no_done: got %0d dones expected 0", done_cnt - snap);
    end
    rand_vals();
    run_sample(0, -1, 0, 0, dc);
    read_check(0, "after_rst_avg");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_timeout();
    test_rd_clear();
    test_overflow();
    test_ignore();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
